mem_line_xfer: RTL and testbench
================================

// Module: mem_line_xfer
// PURPOSE
//  Cache-side initiator for the external memory request/response protocol (mem_req_*, mem_req_data_*, mem_resp_*).
//  Converts one line-sized fill (read) or writeback (write) command from a cache controller into LINE_BEATS single-beat memory transactions.
//  For reads, it reassembles the response beats into one line.
//  Sits between the icache/dcache controllers and the external memory port of riscv_top.
// PARAMETERS
//  MEM_DATA_BITS  128  width of one memory beat
//  MEM_ADDR_BITS  28   memory address width, in beat (16-byte) units
//  MEM_TAG_BITS   5    request/response tag width
//  LINE_BEATS     4    beats per cache line; power of 2, >=2
//  TAG_BASE       0    constant for tag bits above the beat index; distinguishes this engine from other initiators
// PORTS
//  clk                 in   1                      clock; all state updates on posedge
//  reset_n             in   1                      asynchronous reset, active-low
//  cmd_valid           in   1                      line command valid
//  cmd_ready           out  1                      engine idle; accepts a command
//  cmd_write           in   1                      1 = writeback, 0 = fill
//  cmd_line_addr       in   MEM_ADDR_BITS-log2(LB) line address; beat address = {line_addr, beat}
//  cmd_wdata           in   LINE_BEATS*MEM_DATA_BITS write line; beat 0 is in the LSBs
//  cmd_wmask           in   LINE_BEATS*MEM_DATA_BITS/8 per-byte write enables
//  done_valid          out  1                      one-cycle pulse; command complete
//  done_rdata          out  LINE_BEATS*MEM_DATA_BITS fill data; held until the next fill completes
//  mem_req_valid       out  1                      request valid
//  mem_req_ready       in   1                      memory accepts the request
//  mem_req_rw          out  1                      1 = write
//  mem_req_addr        out  MEM_ADDR_BITS          beat address
//  mem_req_tag         out  MEM_TAG_BITS           {TAG_BASE upper bits, beat index}
//  mem_req_data_valid  out  1                      write beat valid
//  mem_req_data_ready  in   1                      memory accepts the write beat
//  mem_req_data_bits   out  MEM_DATA_BITS          write beat data
//  mem_req_data_mask   out  MEM_DATA_BITS/8        write beat byte mask
//  mem_resp_valid      in   1                      read response valid; no backpressure
//  mem_resp_tag        in   MEM_TAG_BITS           response tag
//  mem_resp_data       in   MEM_DATA_BITS          response data
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE; all counters and done_rdata = 0.
//   - cmd_ready=1; every other output is 0.
//  States: IDLE, WR_REQ, WR_DATA, RD_REQ, RD_WAIT, DONE.
//  IDLE:
//   - cmd_ready=1.
//   - On cmd_valid, latch addr, wdata and wmask; beat=0, rcnt=0.
//   - Go to WR_REQ if cmd_write, else RD_REQ.
//  WR_REQ: mem_req_valid=1, rw=1, addr={line,beat}, tag={TAG_BASE,beat}. On ready, go to WR_DATA.
//  WR_DATA:
//   - mem_req_data_valid=1; bits and mask are slice [beat].
//   - On data_ready: if beat==LINE_BEATS-1, go to DONE; else beat++ and return to WR_REQ.
//  RD_REQ:
//   - mem_req_valid=1, rw=0. On ready, beat++.
//   - After the last beat is accepted, go to RD_WAIT. Back-to-back acceptance gives 1 beat/cycle.
//  Responses (accepted in RD_REQ and RD_WAIT):
//   - A response is accepted only when mem_resp_valid and tag[MSBs]==TAG_BASE.
//   - It writes slice done_rdata[tag[log2(LB)-1:0]] and increments rcnt.
//   - Responses may arrive in any order, including while requests are still issuing.
//   - A response with a foreign tag, or one arriving while idle, is ignored.
//  RD_WAIT: when rcnt reaches LINE_BEATS (including on the same cycle as the final response), go to DONE.
//  DONE: done_valid=1 for exactly 1 cycle, then IDLE. Minimum latency is cmd accept to done = LINE_BEATS+2 cycles (read, zero-wait memory).
//  Outputs are stable while valid is high and ready is low. Valid never drops before the handshake completes.
//  A new command is not accepted before DONE. cmd_valid in any non-IDLE state is ignored.
//  An all-zero wmask beat is still issued; the memory ignores its bytes.
//  Deasserting reset_n mid-transfer aborts it: no done pulse, and outputs return to reset values immediately.
// TESTING
//  - Fill, zero-wait: line_addr=0x10, memory beats A0..A3 in order -> req addrs 0x40..0x43, tags 0..3, one done pulse, done_rdata={A3,A2,A1,A0}.
//  - Fill, out-of-order: response tags 2,0,3,1 with random mem_req_ready stalls -> same assembled line; done occurs exactly 1 cycle after the 4th response.
//  - Writeback: wdata beats W0..W3, mask all-ones on beat 1 only, data_ready stalls 3 cycles -> 4 req/data pairs; beat 1 mask=0xFFFF, others 0; fields stable during stalls.
//  - Foreign tag: TAG_BASE=0x10, inject a response with tag 0x02 mid-fill -> ignored; rcnt unchanged; line correct.
//  - Reset mid-fill after 2 beats accepted -> outputs 0 and cmd_ready=1 asynchronously; no done pulse; next fill completes correctly.
//  - Back-to-back: a fill followed by a writeback with cmd_valid held -> second command accepted the cycle after done.

Source files
------------

// File: rtl/mem_line_xfer.sv
// mem_line_xfer
//   Cache-side initiator for the external memory request/response protocol.
//   Turns one line-sized fill (read) or writeback (write) command into
//   LINE_BEATS single-beat memory transactions. Fill responses may return in
//   any order and are reassembled into done_rdata by the low tag bits.
//
// Ports
//   clk, reset_n                  clock (posedge), asynchronous active-low reset
//   cmd_valid / cmd_ready         line command handshake (ready only when idle)
//   cmd_write                     1 = writeback, 0 = fill
//   cmd_line_addr                 line address; beat address = {line, beat}
//   cmd_wdata / cmd_wmask         writeback line and byte enables (beat 0 in LSBs)
//   done_valid                    one-cycle completion pulse
//   done_rdata                    assembled fill line
//   mem_req_valid/ready/rw/addr/tag               request channel
//   mem_req_data_valid/ready/bits/mask            write data channel
//   mem_resp_valid/tag/data                       response channel (no backpressure)
module mem_line_xfer #(
  parameter int MEM_DATA_BITS = 128,
  parameter int MEM_ADDR_BITS = 28,
  parameter int MEM_TAG_BITS  = 5,
  parameter int LINE_BEATS    = 4,
  parameter logic [MEM_TAG_BITS-1:0] TAG_BASE = '0
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic                                   cmd_write,
  input  logic [MEM_ADDR_BITS-$clog2(LINE_BEATS)-1:0] cmd_line_addr,
  input  logic [LINE_BEATS*MEM_DATA_BITS-1:0]    cmd_wdata,
  input  logic [LINE_BEATS*MEM_DATA_BITS/8-1:0]  cmd_wmask,
  output logic                                   done_valid,
  output logic [LINE_BEATS*MEM_DATA_BITS-1:0]    done_rdata,
  output logic                                   mem_req_valid,
  input  logic                                   mem_req_ready,
  output logic                                   mem_req_rw,
  output logic [MEM_ADDR_BITS-1:0]               mem_req_addr,
  output logic [MEM_TAG_BITS-1:0]                mem_req_tag,
  output logic                                   mem_req_data_valid,
  input  logic                                   mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]               mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0]             mem_req_data_mask,
  input  logic                                   mem_resp_valid,
  input  logic [MEM_TAG_BITS-1:0]                mem_resp_tag,
  input  logic [MEM_DATA_BITS-1:0]               mem_resp_data
);

  localparam int BW  = $clog2(LINE_BEATS);
  localparam int LAW = MEM_ADDR_BITS - BW;
  localparam int MB  = MEM_DATA_BITS / 8;

  localparam logic [BW-1:0]              LAST_BEAT = BW'(LINE_BEATS - 1);
  localparam logic [BW:0]                FULL_CNT  = (BW+1)'(LINE_BEATS);
  localparam logic [MEM_TAG_BITS-BW-1:0] TAG_HI    = TAG_BASE[MEM_TAG_BITS-1:BW];

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]                          state;
  logic [BW-1:0]                       beat;
  logic [BW:0]                         rcnt;
  logic [LAW-1:0]                      line;
  logic [LINE_BEATS*MEM_DATA_BITS-1:0] wdata;
  logic [LINE_BEATS*MB-1:0]            wmask;

  logic          resp_hit;
  logic [BW-1:0] resp_idx;
  logic [BW:0]   rcnt_next;
  logic          rd_full;
  logic          last_beat;

  // Only responses carrying this engine's upper tag bits count, and only
  // while a fill is in flight.
  assign resp_hit  = mem_resp_valid
                   && ((state == S_RD_REQ) || (state == S_RD_WAIT))
                   && (mem_resp_tag[MEM_TAG_BITS-1:BW] == TAG_HI);
  assign resp_idx  = mem_resp_tag[BW-1:0];
  assign rcnt_next = rcnt + {{BW{1'b0}}, resp_hit};
  assign rd_full   = (rcnt_next == FULL_CNT);
  assign last_beat = (beat == LAST_BEAT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      beat       <= '0;
      rcnt       <= '0;
      done_rdata <= '0;
    end else begin
      if (resp_hit) begin
        done_rdata[resp_idx*MEM_DATA_BITS +: MEM_DATA_BITS] <= mem_resp_data;
        rcnt <= rcnt_next;
      end
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            beat  <= '0;
            rcnt  <= '0;
            state <= cmd_write ? S_WR_REQ : S_RD_REQ;
          end
        end
        S_WR_REQ: begin
          if (mem_req_ready) state <= S_WR_DATA;
        end
        S_WR_DATA: begin
          if (mem_req_data_ready) begin
            if (last_beat) begin
              state <= S_DONE;
            end else begin
              beat  <= beat + 1'b1;
              state <= S_WR_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (mem_req_ready) begin
            beat <= beat + 1'b1;
            // A fast memory could complete the line while the last request
            // is still being accepted; skip RD_WAIT in that case.
            if (last_beat) state <= rd_full ? S_DONE : S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (rd_full) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Command payload is captured only on acceptance; it never reaches an
  // output outside the states that qualify it, so it needs no reset.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && cmd_valid) begin
      line  <= cmd_line_addr;
      wdata <= cmd_wdata;
      wmask <= cmd_wmask;
    end
  end

  // All outputs are decoded from registered state, so they hold steady while
  // waiting on a handshake and drop to zero immediately on reset.
  always_comb begin
    cmd_ready          = (state == S_IDLE);
    done_valid         = (state == S_DONE);
    mem_req_valid      = 1'b0;
    mem_req_rw         = 1'b0;
    mem_req_addr       = '0;
    mem_req_tag        = '0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;
    if ((state == S_WR_REQ) || (state == S_RD_REQ)) begin
      mem_req_valid = 1'b1;
      mem_req_rw    = (state == S_WR_REQ);
      mem_req_addr  = {line, beat};
      mem_req_tag   = {TAG_HI, beat};
    end
    if (state == S_WR_DATA) begin
      mem_req_data_valid = 1'b1;
      mem_req_data_bits  = wdata[beat*MEM_DATA_BITS +: MEM_DATA_BITS];
      mem_req_data_mask  = wmask[beat*MB +: MB];
    end
  end

endmodule

// File: tb/tb_mem_line_xfer.sv
// tb_mem_line_xfer
//   Directed bench for mem_line_xfer with TAG_BASE = 5'h10, so this engine's
//   tags are {3'b100, beat} = 0x10..0x13 and tag 0x02 is foreign.
module tb_mem_line_xfer;

  logic         clk;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [25:0]  cmd_line_addr;
  logic [511:0] cmd_wdata;
  logic [63:0]  cmd_wmask;
  logic         done_valid;
  logic [511:0] done_rdata;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [4:0]   mem_req_tag;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [4:0]   mem_resp_tag;
  logic [127:0] mem_resp_data;

  int tests = 0;
  int fails = 0;

  mem_line_xfer #(
    .MEM_DATA_BITS(128),
    .MEM_ADDR_BITS(28),
    .MEM_TAG_BITS (5),
    .LINE_BEATS   (4),
    .TAG_BASE     (5'h10)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_line_addr     (cmd_line_addr),
    .cmd_wdata         (cmd_wdata),
    .cmd_wmask         (cmd_wmask),
    .done_valid        (done_valid),
    .done_rdata        (done_rdata),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_rw        (mem_req_rw),
    .mem_req_addr      (mem_req_addr),
    .mem_req_tag       (mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits (mem_req_data_bits),
    .mem_req_data_mask (mem_req_data_mask),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_tag      (mem_resp_tag),
    .mem_resp_data     (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fill: each request accepted immediately, its response returned
  // the following cycle. With hold set, a writeback command is left pending
  // on the command port while the fill runs.
  task automatic fill_zw(input logic [25:0] ln, input bit hold);
    logic [127:0] a [4];
    logic [27:0]  ea;
    for (int i = 0; i < 4; i++) a[i] = {32'(ln), 32'(i), 64'hA5A5_0000_0000_5A5A ^ 64'(i * 7)};
    cmd_valid     = 1'b1;
    cmd_write     = 1'b0;
    cmd_line_addr = ln;
    mem_req_ready = 1'b1;
    chk("fill_cmd_ready_idle", cmd_ready, 1);
    step();
    chk("fill_cmd_ready_busy", cmd_ready, 0);
    if (hold) begin
      cmd_write     = 1'b1;
      cmd_line_addr = 26'h8;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        ea = {ln, 2'(i)};
        chk("fill_req_valid", mem_req_valid, 1);
        chk("fill_req_rw", mem_req_rw, 0);
        chk("fill_req_addr", mem_req_addr, ea);
        chk("fill_req_tag", mem_req_tag, 5'h10 + 5'(i));
      end else begin
        chk("fill_req_valid_wait", mem_req_valid, 0);
      end
      chk("fill_no_early_done", done_valid, 0);
      if (i > 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 5'h10 + 5'(i - 1);
        mem_resp_data  = a[i-1];
      end
      step();
      mem_resp_valid = 1'b0;
    end
    chk("fill_done", done_valid, 1);
    chk("fill_rdata", done_rdata, {a[3], a[2], a[1], a[0]});
    step();
    chk("fill_done_pulse", done_valid, 0);
  endtask

  initial begin
    logic [127:0] b [4];
    logic [127:0] w [4];
    logic [4:0]   rtag [5];
    logic [127:0] rdat [5];
    logic [7:0]   pat;
    logic [511:0] line_b;
    int           cnt;
    int           k;
    bit           seen;

    reset_n            = 1'b0;
    cmd_valid          = 1'b0;
    cmd_write          = 1'b0;
    cmd_line_addr      = '0;
    cmd_wdata          = '0;
    cmd_wmask          = '0;
    mem_req_ready      = 1'b0;
    mem_req_data_ready = 1'b0;
    mem_resp_valid     = 1'b0;
    mem_resp_tag       = '0;
    mem_resp_data      = '0;

    // Reset values
    #3;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_data_valid", mem_req_data_valid, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_rdata", done_rdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Fill, zero-wait: line 0x10 -> beat addresses 0x40..0x43
    fill_zw(26'h10, 1'b0);
    chk("t1_cmd_ready_after", cmd_ready, 1);

    // Fill, out-of-order responses with request stalls and a foreign tag
    for (int i = 0; i < 4; i++) b[i] = {4{32'hB000_0000 + 32'(i)}};
    line_b = {b[3], b[2], b[1], b[0]};
    cmd_valid     = 1'b1;
    cmd_write     = 1'b0;
    cmd_line_addr = 26'h21;
    step();
    cmd_valid = 1'b0;
    pat = 8'b1011_0010;
    cnt = 0;
    k   = 0;
    while (cnt < 4 && k < 40) begin
      chk("t2_req_valid", mem_req_valid, 1);
      chk("t2_req_addr", mem_req_addr, 28'h84 + 28'(cnt));
      chk("t2_req_tag", mem_req_tag, 5'h10 + 5'(cnt));
      mem_req_ready = pat[k % 8];
      step();
      if (mem_req_ready) cnt++;
      k++;
    end
    mem_req_ready = 1'b0;
    chk("t2_all_req_accepted", cnt, 4);
    chk("t2_wait_no_req", mem_req_valid, 0);
    rtag[0] = 5'h12; rdat[0] = b[2];
    rtag[1] = 5'h02; rdat[1] = {4{32'hDEAD_BEEF}};
    rtag[2] = 5'h10; rdat[2] = b[0];
    rtag[3] = 5'h13; rdat[3] = b[3];
    rtag[4] = 5'h11; rdat[4] = b[1];
    for (int j = 0; j < 5; j++) begin
      mem_resp_valid = 1'b1;
      mem_resp_tag   = rtag[j];
      mem_resp_data  = rdat[j];
      step();
      mem_resp_valid = 1'b0;
      if (j < 4) chk("t2_done_not_yet", done_valid, 0);
    end
    chk("t2_done_after_4th", done_valid, 1);
    chk("t2_rdata", done_rdata, line_b);
    step();
    chk("t2_idle", cmd_ready, 1);

    // Writeback: mask only on beat 1, three-cycle data stall on every beat
    for (int i = 0; i < 4; i++) w[i] = {4{32'h5700_0000 + 32'(i)}};
    cmd_valid     = 1'b1;
    cmd_write     = 1'b1;
    cmd_line_addr = 26'h05;
    cmd_wdata     = {w[3], w[2], w[1], w[0]};
    cmd_wmask     = 64'h0000_0000_FFFF_0000;
    mem_req_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_req_valid", mem_req_valid, 1);
      chk("t3_req_rw", mem_req_rw, 1);
      chk("t3_req_addr", mem_req_addr, 28'h14 + 28'(i));
      chk("t3_req_tag", mem_req_tag, 5'h10 + 5'(i));
      chk("t3_no_data_yet", mem_req_data_valid, 0);
      step();
      for (int s = 0; s < 4; s++) begin
        chk("t3_data_valid", mem_req_data_valid, 1);
        chk("t3_data_bits", mem_req_data_bits, w[i]);
        chk("t3_data_mask", mem_req_data_mask, (i == 1) ? 16'hFFFF : 16'h0000);
        chk("t3_req_quiet", mem_req_valid, 0);
        chk("t3_no_early_done", done_valid, 0);
        mem_req_data_ready = (s == 3);
        step();
        mem_req_data_ready = 1'b0;
      end
    end
    chk("t3_done", done_valid, 1);
    chk("t3_rdata_held", done_rdata, line_b);
    step();

    // Reset mid-fill after two beats accepted
    cmd_valid     = 1'b1;
    cmd_write     = 1'b0;
    cmd_line_addr = 26'h30;
    mem_req_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("t4_mid_fill_req", mem_req_addr, 28'hC2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t4_rst_cmd_ready", cmd_ready, 1);
    chk("t4_rst_req_valid", mem_req_valid, 0);
    chk("t4_rst_req_addr", mem_req_addr, 0);
    chk("t4_rst_req_tag", mem_req_tag, 0);
    chk("t4_rst_rdata", done_rdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("t4_no_done_a", done_valid, 0);
    step();
    chk("t4_no_done_b", done_valid, 0);
    fill_zw(26'h30, 1'b0);

    // Back-to-back: writeback held on cmd port during a fill
    fill_zw(26'h07, 1'b1);
    chk("t5_ready_after_done", cmd_ready, 1);
    line_b = done_rdata;
    cmd_wdata     = {4{128'h1234}};
    cmd_wmask     = '1;
    mem_req_data_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("t5_wb_req_valid", mem_req_valid, 1);
    chk("t5_wb_req_rw", mem_req_rw, 1);
    chk("t5_wb_req_addr", mem_req_addr, 28'h20);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (done_valid) seen = 1'b1;
    end
    chk("t5_wb_done", seen, 1);
    chk("t5_rdata_kept", done_rdata, line_b);
    mem_req_data_ready = 1'b0;
    mem_req_ready      = 1'b0;
    step();
    chk("t5_final_idle", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
